// File: rtl/pkt_mux_rr_n_if.sv
// Packet mux bus: N_IN framed input streams in, one framed stream out.
// master = the environment (sources and sink), slave = the mux itself.
interface pkt_mux_rr_n_if #(
    parameter int N_IN    = 4,
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6
);
    localparam int CH_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN*DATA_W-1:0]  in_data;
    logic [N_IN-1:0]         in_valid;
    logic [N_IN-1:0]         in_sop;
    logic [N_IN-1:0]         in_eop;
    logic [N_IN*EMPTY_W-1:0] in_empty;
    logic [N_IN-1:0]         in_ready;

    logic [DATA_W-1:0]       out_data;
    logic                    out_valid;
    logic                    out_sop;
    logic                    out_eop;
    logic [EMPTY_W-1:0]      out_empty;
    logic [CH_W-1:0]         out_channel;
    logic                    out_ready;

    logic [15:0]             err_cnt;

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop, out_empty,
               out_channel, err_cnt
    );

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_empty, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop, out_empty,
               out_channel, err_cnt
    );
endinterface

// File: rtl/pkt_mux_rr_n.sv
// N-input packet multiplexer. A packet, once granted, owns the output until
// its eop beat is accepted. Arbitration is round-robin (MODE 0) or fixed
// priority with input 0 highest (MODE 1). Beats arriving without sop while no
// packet is open are orphans: they are drained and counted in err_cnt.
module pkt_mux_rr_n #(
    parameter int N_IN    = 4,
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int MODE    = 0
) (
    input  logic          clk,
    input  logic          SoftReset,
    pkt_mux_rr_n_if.slave bus
);
    localparam int CH_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [CH_W-1:0]     grant_r;
    logic [CH_W-1:0]     last_grant_r;
    logic [CH_W-1:0]     pick_s;
    logic [CH_W-1:0]     sel_s;
    logic [N_IN-1:0]     cand_s;
    logic [N_IN-1:0]     orphan_s;
    logic [N_IN-1:0]     in_ready_s;
    logic                can_load_s;
    logic                accept_s;

    logic [DATA_W-1:0]   beat_data_s;
    logic [EMPTY_W-1:0]  beat_empty_s;
    logic                beat_sop_s;
    logic                beat_eop_s;

    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r;
    logic                out_sop_r;
    logic                out_eop_r;
    logic [EMPTY_W-1:0]  out_empty_r;
    logic [CH_W-1:0]     out_channel_r;
    logic [15:0]         err_cnt_r;
    logic [16:0]         err_sum_s;

    // Number of set bits; N_IN is at most 8 so four bits always suffice.
    function automatic logic [3:0] popcount(input logic [N_IN-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < N_IN; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

    // First requester found scanning upward from the input after 'last'.
    function automatic logic [CH_W-1:0] rr_pick(input logic [N_IN-1:0] req,
                                                input logic [CH_W-1:0] last);
        logic [CH_W-1:0] pick;
        logic [CH_W-1:0] idx;
        logic            found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_IN; k++) begin
            idx = CH_W'((int'(last) + k) % N_IN);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Lowest-index requester; scanning downward lets the lowest win last.
    function automatic logic [CH_W-1:0] fp_pick(input logic [N_IN-1:0] req);
        logic [CH_W-1:0] pick;
        pick = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            pick = req[i] ? CH_W'(i) : pick;
        end
        return pick;
    endfunction

    assign can_load_s = !out_valid_r || bus.out_ready;
    assign cand_s     = bus.in_valid & bus.in_sop;
    assign pick_s     = (MODE == 1) ? fp_pick(cand_s) : rr_pick(cand_s, last_grant_r);

    // Next state, handshake and orphan-drain decisions for the current cycle.
    always_comb begin
        state_nx_s = state_r;
        in_ready_s = '0;
        orphan_s   = '0;
        accept_s   = 1'b0;
        sel_s      = grant_r;
        if (SoftReset) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    orphan_s   = bus.in_valid & ~bus.in_sop;
                    in_ready_s = orphan_s;
                    sel_s      = pick_s;
                    if (can_load_s && (cand_s != '0)) begin
                        accept_s           = 1'b1;
                        in_ready_s[pick_s] = 1'b1;
                        state_nx_s         = bus.in_eop[pick_s] ? ST_IDLE : ST_LOCK;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_LOCK: begin
                    sel_s               = grant_r;
                    in_ready_s[grant_r] = can_load_s;
                    if (can_load_s && bus.in_valid[grant_r]) begin
                        accept_s   = 1'b1;
                        state_nx_s = bus.in_eop[grant_r] ? ST_IDLE : ST_LOCK;
                    end else begin
                        state_nx_s = ST_LOCK;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // AND-OR select of the beat presented by the selected input.
    always_comb begin
        beat_data_s  = '0;
        beat_empty_s = '0;
        beat_sop_s   = 1'b0;
        beat_eop_s   = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            beat_data_s  = beat_data_s  | ({DATA_W{sel_s == CH_W'(i)}} & bus.in_data[i*DATA_W +: DATA_W]);
            beat_empty_s = beat_empty_s | ({EMPTY_W{sel_s == CH_W'(i)}} & bus.in_empty[i*EMPTY_W +: EMPTY_W]);
            beat_sop_s   = beat_sop_s   | ((sel_s == CH_W'(i)) & bus.in_sop[i]);
            beat_eop_s   = beat_eop_s   | ((sel_s == CH_W'(i)) & bus.in_eop[i]);
        end
    end

    // FSM state plus the locked input and round-robin pointer, both moved only on a new grant.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= CH_W'(N_IN - 1);
        end else begin
            state_r <= state_nx_s;
            if (accept_s && (state_r == ST_IDLE)) begin
                grant_r      <= pick_s;
                last_grant_r <= pick_s;
            end else begin
                grant_r      <= grant_r;
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Single output register; holds everything while the sink stalls a valid beat.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            out_valid_r   <= 1'b0;
            out_sop_r     <= 1'b0;
            out_eop_r     <= 1'b0;
            out_empty_r   <= '0;
            out_channel_r <= '0;
            out_data_r    <= '0;
        end else if (can_load_s) begin
            out_valid_r <= accept_s;
            if (accept_s) begin
                out_sop_r     <= beat_sop_s;
                out_eop_r     <= beat_eop_s;
                out_empty_r   <= beat_empty_s;
                out_channel_r <= sel_s;
                out_data_r    <= beat_data_s;
            end else begin
                out_sop_r     <= out_sop_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign err_sum_s = {1'b0, err_cnt_r} + {13'd0, popcount(orphan_s)};

    // Saturating count of drained orphan beats.
    always_ff @(posedge clk) begin
        if (SoftReset) begin
            err_cnt_r <= 16'd0;
        end else begin
            err_cnt_r <= err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_data    = out_data_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_sop     = out_sop_r;
    assign bus.out_eop     = out_eop_r;
    assign bus.out_empty   = out_empty_r;
    assign bus.out_channel = out_channel_r;
    assign bus.err_cnt     = err_cnt_r;
endmodule

// File: tb/tb_pkt_mux_rr_n.sv
// Directed bench for pkt_mux_rr_n: a round-robin instance (dut0) and a
// fixed-priority instance (dut1) sharing clock and reset.
module tb_pkt_mux_rr_n;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int EW = 6;

    logic clk;
    logic soft_reset;
    int   checks;
    int   failures;

    pkt_mux_rr_n_if #(.N_IN(N), .DATA_W(DW), .EMPTY_W(EW)) bus0 ();
    pkt_mux_rr_n_if #(.N_IN(N), .DATA_W(DW), .EMPTY_W(EW)) bus1 ();

    pkt_mux_rr_n #(.N_IN(N), .DATA_W(DW), .EMPTY_W(EW), .MODE(0)) dut0 (
        .clk       (clk),
        .SoftReset (soft_reset),
        .bus       (bus0.slave)
    );

    pkt_mux_rr_n #(.N_IN(N), .DATA_W(DW), .EMPTY_W(EW), .MODE(1)) dut1 (
        .clk       (clk),
        .SoftReset (soft_reset),
        .bus       (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat payload: {channel, packet number, beat number, marker}.
    function automatic logic [31:0] mk(input int ch, input int pkt, input int beat);
        logic [7:0] c;
        logic [7:0] p;
        logic [7:0] b;
        c = 8'(ch);
        p = 8'(pkt);
        b = 8'(beat);
        return {c, p, b, 8'hA5};
    endfunction

    task automatic drv0(input int ch, input logic v, input logic sop, input logic eop, input logic [31:0] d);
        bus0.in_valid[ch]          = v;
        bus0.in_sop[ch]            = sop;
        bus0.in_eop[ch]            = eop;
        bus0.in_data[ch*DW +: DW]  = d;
        bus0.in_empty[ch*EW +: EW] = d[13:8];
    endtask

    task automatic drv1(input int ch, input logic v, input logic sop, input logic eop, input logic [31:0] d);
        bus1.in_valid[ch]          = v;
        bus1.in_sop[ch]            = sop;
        bus1.in_eop[ch]            = eop;
        bus1.in_data[ch*DW +: DW]  = d;
        bus1.in_empty[ch*EW +: EW] = d[13:8];
    endtask

    task automatic idle_all();
        bus0.in_valid = '0; bus0.in_sop = '0; bus0.in_eop = '0;
        bus0.in_data  = '0; bus0.in_empty = '0;
        bus1.in_valid = '0; bus1.in_sop = '0; bus1.in_eop = '0;
        bus1.in_data  = '0; bus1.in_empty = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_all();
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
    endtask

    task automatic test_reset();
        soft_reset     = 1'b1;
        idle_all();
        bus0.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < N; i++) drv0(i, 1'b1, 1'b1, 1'b1, mk(i, 0, 0));
        tick();
        tick();
        #1;
        checks++;
        if (bus0.in_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_in_ready: got %b want 0000", bus0.in_ready);
        end
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.out_sop !== 1'b0 || bus0.out_eop !== 1'b0) begin
            failures++; $display("FAIL reset_out_flags: got v=%b s=%b e=%b want 0 0 0", bus0.out_valid, bus0.out_sop, bus0.out_eop);
        end
        checks++;
        if (bus0.out_data !== 32'h0 || bus0.out_empty !== 6'h0 || bus0.out_channel !== 2'd0) begin
            failures++; $display("FAIL reset_out_fields: got d=%h e=%h ch=%0d want 0 0 0", bus0.out_data, bus0.out_empty, bus0.out_channel);
        end
        checks++;
        if (bus0.err_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_err_cnt: got %0d want 0", bus0.err_cnt);
        end
        soft_reset = 1'b0;
        #1;
        checks++;
        if (bus0.in_ready !== 4'b0001) begin
            failures++; $display("FAIL reset_first_grant_ready: got %b want 0001", bus0.in_ready);
        end
        tick();
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_channel !== 2'd0 || bus0.out_data !== mk(0, 0, 0)) begin
            failures++; $display("FAIL reset_first_grant_out: got v=%b ch=%0d d=%h want 1 0 %h", bus0.out_valid, bus0.out_channel, bus0.out_data, mk(0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        int beat[N];
        int pkt[N];
        logic [3:0] rdy;
        int ec;
        int eb;
        int ep;
        do_reset();
        bus0.out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin beat[i] = 0; pkt[i] = 0; end
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++) drv0(i, 1'b1, beat[i] == 0, beat[i] == 2, mk(i, pkt[i], beat[i]));
            #1 rdy = bus0.in_ready;
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    if (beat[i] == 2) begin beat[i] = 0; pkt[i]++; end
                    else beat[i]++;
                end
            end
            #1;
            ec = (k / 3) % 4;
            eb = k % 3;
            ep = k / 12;
            checks++;
            if (bus0.out_valid !== 1'b1 || bus0.out_channel !== 2'(ec) || bus0.out_data !== mk(ec, ep, eb)
                || bus0.out_sop !== (eb == 0) || bus0.out_eop !== (eb == 2) || bus0.out_empty !== 6'(eb)) begin
                failures++;
                $display("FAIL b2b_beat%0d: got v=%b ch=%0d d=%h s=%b e=%b want 1 ch=%0d d=%h", k,
                         bus0.out_valid, bus0.out_channel, bus0.out_data, bus0.out_sop, bus0.out_eop, ec, mk(ec, ep, eb));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus0.out_ready = 1'b1;
        drv0(1, 1'b1, 1'b1, 1'b0, mk(1, 0, 0));
        tick();
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_channel !== 2'd1 || bus0.out_data !== mk(1, 0, 0) || bus0.out_sop !== 1'b1) begin
            failures++; $display("FAIL bp_beat0: got v=%b ch=%0d d=%h want 1 1 %h", bus0.out_valid, bus0.out_channel, bus0.out_data, mk(1, 0, 0));
        end
        drv0(1, 1'b1, 1'b0, 1'b0, mk(1, 0, 1));
        tick();
        bus0.out_ready = 1'b0;
        drv0(1, 1'b1, 1'b0, 1'b0, mk(1, 0, 2));
        for (int s = 0; s < 5; s++) begin
            #1;
            checks++;
            if (bus0.in_ready !== 4'b0000) begin
                failures++; $display("FAIL bp_stall_ready%0d: got %b want 0000", s, bus0.in_ready);
            end
            tick();
            checks++;
            if (bus0.out_valid !== 1'b1 || bus0.out_data !== mk(1, 0, 1) || bus0.out_sop !== 1'b0
                || bus0.out_eop !== 1'b0 || bus0.out_channel !== 2'd1 || bus0.out_empty !== 6'd1) begin
                failures++; $display("FAIL bp_stall_hold%0d: got v=%b d=%h want 1 %h", s, bus0.out_valid, bus0.out_data, mk(1, 0, 1));
            end
        end
        bus0.out_ready = 1'b1;
        #1;
        checks++;
        if (bus0.in_ready !== 4'b0010) begin
            failures++; $display("FAIL bp_resume_ready: got %b want 0010", bus0.in_ready);
        end
        tick();
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_data !== mk(1, 0, 2)) begin
            failures++; $display("FAIL bp_beat2: got v=%b d=%h want 1 %h", bus0.out_valid, bus0.out_data, mk(1, 0, 2));
        end
        drv0(1, 1'b1, 1'b0, 1'b1, mk(1, 0, 3));
        tick();
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_data !== mk(1, 0, 3) || bus0.out_eop !== 1'b1) begin
            failures++; $display("FAIL bp_beat3: got v=%b d=%h e=%b want 1 %h 1", bus0.out_valid, bus0.out_data, bus0.out_eop, mk(1, 0, 3));
        end
        drv0(1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_drained: got v=%b want 0", bus0.out_valid);
        end
    endtask

    task automatic test_priority();
        do_reset();
        bus1.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv1(1, 1'b1, 1'b1, 1'b1, mk(1, k, 0));
            drv1(3, 1'b1, 1'b1, 1'b1, mk(3, k, 0));
            #1;
            checks++;
            if (bus1.in_ready !== 4'b0010) begin
                failures++; $display("FAIL prio_ready%0d: got %b want 0010", k, bus1.in_ready);
            end
            tick();
            checks++;
            if (bus1.out_valid !== 1'b1 || bus1.out_channel !== 2'd1 || bus1.out_data !== mk(1, k, 0)) begin
                failures++; $display("FAIL prio_out%0d: got v=%b ch=%0d d=%h want 1 1 %h", k, bus1.out_valid, bus1.out_channel, bus1.out_data, mk(1, k, 0));
            end
        end
        drv1(1, 1'b0, 1'b0, 1'b0, 32'h0);
        drv1(3, 1'b1, 1'b1, 1'b1, mk(3, 9, 0));
        #1;
        checks++;
        if (bus1.in_ready !== 4'b1000) begin
            failures++; $display("FAIL prio_ch3_ready: got %b want 1000", bus1.in_ready);
        end
        tick();
        checks++;
        if (bus1.out_valid !== 1'b1 || bus1.out_channel !== 2'd3 || bus1.out_data !== mk(3, 9, 0)) begin
            failures++; $display("FAIL prio_ch3_out: got v=%b ch=%0d d=%h want 1 3 %h", bus1.out_valid, bus1.out_channel, bus1.out_data, mk(3, 9, 0));
        end
        drv1(1, 1'b1, 1'b1, 1'b1, mk(1, 7, 0));
        #1;
        checks++;
        if (bus1.in_ready !== 4'b0010) begin
            failures++; $display("FAIL prio_ch1_back: got %b want 0010", bus1.in_ready);
        end
        tick();
        idle_all();
    endtask

    task automatic test_single_beat();
        logic [3:0] exp_rdy;
        do_reset();
        bus0.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) drv0(i, 1'b1, 1'b1, 1'b1, mk(i, k, 0));
            exp_rdy = 4'b0001 << (k % 4);
            #1;
            checks++;
            if (bus0.in_ready !== exp_rdy) begin
                failures++; $display("FAIL single_ready%0d: got %b want %b", k, bus0.in_ready, exp_rdy);
            end
            tick();
            checks++;
            if (bus0.out_valid !== 1'b1 || bus0.out_channel !== 2'(k % 4) || bus0.out_sop !== 1'b1
                || bus0.out_eop !== 1'b1 || bus0.out_data !== mk(k % 4, k, 0)) begin
                failures++; $display("FAIL single_out%0d: got ch=%0d d=%h want ch=%0d d=%h", k, bus0.out_channel, bus0.out_data, k % 4, mk(k % 4, k, 0));
            end
        end
    endtask

    task automatic test_orphans();
        do_reset();
        bus0.out_ready = 1'b1;
        drv0(0, 1'b1, 1'b1, 1'b0, mk(0, 0, 0));
        drv0(2, 1'b1, 1'b0, 1'b0, mk(2, 0, 0));
        #1;
        checks++;
        if (bus0.in_ready !== 4'b0101) begin
            failures++; $display("FAIL orph_ready_c0: got %b want 0101", bus0.in_ready);
        end
        tick();
        for (int b = 1; b < 4; b++) begin
            checks++;
            if (bus0.out_valid !== 1'b1 || bus0.out_channel !== 2'd0 || bus0.out_data !== mk(0, 0, b - 1) || bus0.err_cnt !== 16'd1) begin
                failures++; $display("FAIL orph_pkt_beat%0d: got d=%h err=%0d want %h err=1", b - 1, bus0.out_data, bus0.err_cnt, mk(0, 0, b - 1));
            end
            drv0(0, 1'b1, 1'b0, b == 3, mk(0, 0, b));
            drv0(2, 1'b1, 1'b0, 1'b0, mk(2, 0, 1));
            #1;
            checks++;
            if (bus0.in_ready !== 4'b0001) begin
                failures++; $display("FAIL orph_locked_ready%0d: got %b want 0001", b, bus0.in_ready);
            end
            tick();
        end
        checks++;
        if (bus0.out_data !== mk(0, 0, 3) || bus0.out_eop !== 1'b1 || bus0.err_cnt !== 16'd1) begin
            failures++; $display("FAIL orph_pkt_last: got d=%h e=%b err=%0d want %h 1 1", bus0.out_data, bus0.out_eop, bus0.err_cnt, mk(0, 0, 3));
        end
        drv0(0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int o = 1; o < 4; o++) begin
            drv0(2, 1'b1, 1'b0, 1'b0, mk(2, 0, o));
            tick();
        end
        drv0(2, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if (bus0.err_cnt !== 16'd4 || bus0.out_valid !== 1'b0) begin
            failures++; $display("FAIL orph_err_total: got err=%0d v=%b want 4 0", bus0.err_cnt, bus0.out_valid);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus0.out_ready = 1'b1;
        drv0(1, 1'b1, 1'b1, 1'b0, mk(1, 0, 0));
        tick();
        drv0(1, 1'b1, 1'b0, 1'b0, mk(1, 0, 1));
        tick();
        checks++;
        if (bus0.out_data !== mk(1, 0, 1) || bus0.out_valid !== 1'b1) begin
            failures++; $display("FAIL rmp_pre: got d=%h v=%b want %h 1", bus0.out_data, bus0.out_valid, mk(1, 0, 1));
        end
        soft_reset = 1'b1;
        drv0(1, 1'b1, 1'b0, 1'b0, mk(1, 0, 2));
        #1;
        checks++;
        if (bus0.in_ready !== 4'b0000) begin
            failures++; $display("FAIL rmp_ready_in_reset: got %b want 0000", bus0.in_ready);
        end
        tick();
        soft_reset = 1'b0;
        checks++;
        if (bus0.out_valid !== 1'b0) begin
            failures++; $display("FAIL rmp_out_cleared: got v=%b want 0", bus0.out_valid);
        end
        #1;
        checks++;
        if (bus0.in_ready !== 4'b0010) begin
            failures++; $display("FAIL rmp_drain_ready: got %b want 0010", bus0.in_ready);
        end
        tick();
        drv0(1, 1'b1, 1'b0, 1'b1, mk(1, 0, 3));
        tick();
        checks++;
        if (bus0.err_cnt !== 16'd2 || bus0.out_valid !== 1'b0) begin
            failures++; $display("FAIL rmp_err: got err=%0d v=%b want 2 0", bus0.err_cnt, bus0.out_valid);
        end
        drv0(1, 1'b1, 1'b1, 1'b1, mk(1, 1, 0));
        tick();
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_channel !== 2'd1 || bus0.out_data !== mk(1, 1, 0) || bus0.err_cnt !== 16'd2) begin
            failures++; $display("FAIL rmp_next_pkt: got v=%b ch=%0d d=%h err=%0d want 1 1 %h 2",
                                 bus0.out_valid, bus0.out_channel, bus0.out_data, bus0.err_cnt, mk(1, 1, 0));
        end
        drv0(1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_err_saturation();
        do_reset();
        bus0.out_ready = 1'b0;
        for (int i = 0; i < N; i++) drv0(i, 1'b1, 1'b0, 1'b0, mk(i, 0, 0));
        #1;
        checks++;
        if (bus0.in_ready !== 4'b1111) begin
            failures++; $display("FAIL sat_drain_ready: got %b want 1111", bus0.in_ready);
        end
        repeat (16383) @(posedge clk);
        #1;
        checks++;
        if (bus0.err_cnt !== 16'hFFFC) begin
            failures++; $display("FAIL sat_near: got %h want fffc", bus0.err_cnt);
        end
        tick();
        checks++;
        if (bus0.err_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL sat_clip: got %h want ffff", bus0.err_cnt);
        end
        tick();
        checks++;
        if (bus0.err_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL sat_hold: got %h want ffff", bus0.err_cnt);
        end
        idle_all();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_priority();
        test_single_beat();
        test_orphans();
        test_reset_mid_packet();
        test_err_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pkt_mux_rr_n.md
PKT_MUX_RR_N -- requirements
Module: pkt_mux_rr_n

Interface
REQ-001 Parameter N_IN, default 4: number of input channels, legal 2..8.
REQ-002 Parameter DATA_W, default 512: beat data width.
REQ-003 Parameter EMPTY_W, default 6: empty-byte field width.
REQ-004 Parameter MODE, default 0: 0 = round-robin, 1 = fixed priority with input 0 highest.
REQ-005 Localparam CH_W = max(1, clog2(N_IN)).
REQ-006 Port clk, input, 1: single clock; all logic is clocked on its rising edge.
REQ-007 Port SoftReset, input, 1: reset, synchronous and active-high.
REQ-008 Port in_data, input, N_IN*DATA_W: per-input data; input i occupies bits [i*DATA_W +: DATA_W].
REQ-009 Port in_valid / in_sop / in_eop, input, N_IN each: per-input valid, start-of-packet and end-of-packet.
REQ-010 Port in_empty, input, N_IN*EMPTY_W: per-input empty byte count.
REQ-011 Port in_ready, output, N_IN: per-input ready.
REQ-012 Port out_data, output, DATA_W.
REQ-013 Ports out_valid / out_sop / out_eop, output, 1 each.
REQ-014 Port out_empty, output, EMPTY_W.
REQ-015 Port out_channel, output, CH_W: index of the source input for the current beat.
REQ-016 Port out_ready, input, 1: downstream ready.
REQ-017 Port err_cnt, output, 16: count of dropped orphan beats; saturates at 0xFFFF.

Function
REQ-018 A beat transfers on an input when in_valid[i] and in_ready[i] are both 1 in the same cycle; a beat transfers on the output when out_valid and out_ready are both 1.
REQ-019 All out_* signals come from a single output register; it loads when (!out_valid || out_ready); accepted-to-output latency is exactly 1 cycle.
REQ-020 While out_valid=1 and out_ready=0, all out_* signals hold stable.
REQ-021 FSM states: IDLE (no packet in progress) and LOCK (packet from input g in progress).
REQ-022 IDLE: the candidate set is every i with in_valid[i] && in_sop[i]; when the output register can load and the set is non-empty, grant one input g and accept its beat.
REQ-023 IDLE to LOCK transition happens on a granted beat with in_eop=0; a granted beat with sop and eop both 1 keeps the FSM in IDLE.
REQ-024 LOCK: in_ready[g] = (!out_valid || out_ready); all other in_ready are 0 except the orphan drain below.
REQ-025 LOCK to IDLE transition happens when a beat with in_eop=1 is accepted from g; the next cycle may grant a new packet, with no idle bubble between packets.
REQ-026 In LOCK, in_sop on g is ignored and forwarded as-is; packet framing is determined by eop only.
REQ-027 MODE 0 round-robin: the search starts at (last_grant+1) mod N_IN; last_grant updates only on a grant.
REQ-028 MODE 1 fixed priority: the lowest-index candidate wins.
REQ-029 Orphan drain: in IDLE, any input i with in_valid[i] && !in_sop[i] gets in_ready[i]=1 regardless of output state, and its beat is discarded.
REQ-030 Each discarded beat increments err_cnt by 1; multiple beats dropped in the same cycle add their total count; err_cnt saturates at 0xFFFF.
REQ-031 An orphan drain and a grant to a different input may occur in the same cycle.
REQ-032 out_channel is set to g, and out_sop/out_eop/out_empty/out_data are copied from the accepted beat.
REQ-033 Inputs that are not granted and not orphan have in_ready=0, and their beats are not consumed.

Reset
REQ-034 While SoftReset=1 at a clock edge, the block goes to: FSM IDLE, last_grant = N_IN-1 (first RR search starts at input 0), out_valid=0, out_sop=0, out_eop=0, out_empty=0, out_channel=0, out_data=0, err_cnt=0.
REQ-035 All in_ready outputs are 0 while SoftReset=1.
REQ-036 A reset during a packet abandons that packet; after reset, the remaining beats from that input are orphans and are dropped per REQ-029.

Verification
REQ-037 Back-to-back traffic: inputs 0..3 each present a 3-beat packet every cycle with out_ready=1 (MODE 0) -> output order is channel 0,1,2,3,0,...; packets are never interleaved; output is 100% valid after the first cycle.
REQ-038 Backpressure: out_ready held 0 for 5 cycles mid-packet -> out_* stay stable; no beat is lost or duplicated; in_ready[g]=0 during the stall.
REQ-039 Priority mode: MODE 1 with inputs 1 and 3 continuously valid -> only channel 1 is granted while it stays valid; channel 3 is granted when input 1 drops valid in IDLE.
REQ-040 Single-beat packets (sop=eop=1) on all inputs -> one grant per cycle in rotation; FSM never enters LOCK.
REQ-041 Orphans: input 2 sends 4 beats with sop=0 while input 0 sends a packet -> the 4 beats are dropped, err_cnt=4, and input 0's packet is delivered intact.
REQ-042 Reset mid-packet, then the remaining 2 beats -> out_valid=0 the next cycle, err_cnt=2, and the next sop packet is delivered normally.
